// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: program-counter sequencer and fetch buffer for the RV32
// instruction memory. Drives the word address into a combinational memory,
// captures {pc, inst} pairs into a small FIFO and hands them to decode over
// a valid/ready handshake. A redirect port serves branches/jumps and an
// all-zero fetched word optionally halts fetch.
// Optional feature: define IFETCH_MISALIGN_TRAP_EN to reject misaligned
// redirect targets and report them on o_misalign / o_misalign_pc. Without it,
// redirect targets are silently word aligned.
module inst_fetch_ctrl #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC     = '0,
  parameter int                    BUF_DEPTH    = 2,
  parameter int                    HALT_ON_ZERO = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  output logic [ADDR_WIDTH-1:0] o_imem_addr,
  input  logic [31:0]           i_imem_inst,
  output logic                  o_inst_valid,
  input  logic                  i_inst_ready,
  output logic [31:0]           o_inst,
  output logic [ADDR_WIDTH-1:0] o_inst_pc,
  input  logic                  i_redirect_valid,
  input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
  output logic                  o_halted
`ifdef IFETCH_MISALIGN_TRAP_EN
  ,
  output logic                  o_misalign,
  output logic [ADDR_WIDTH-1:0] o_misalign_pc
`endif
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc, pc_nxt;

  logic [ADDR_WIDTH-1:0] fifo_pc   [BUF_DEPTH];
  logic [31:0]           fifo_inst [BUF_DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count;

  logic                  pop;
  logic                  push;
  logic                  flush;
  logic                  has_room;
  logic                  inst_zero;
  logic                  redir;
  logic [ADDR_WIDTH-1:0] redir_tgt;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic redir_mis;

  // A misaligned target is rejected outright; only aligned targets redirect.
  assign redir_mis = i_redirect_valid && (i_redirect_pc[1:0] != 2'b00);
  assign redir     = i_redirect_valid && !redir_mis;
  assign redir_tgt = i_redirect_pc;
`else
  // Clear the byte-offset bits so the PC always stays word aligned.
  function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] a);
    return a & ~ADDR_WIDTH'(3);
  endfunction

  assign redir     = i_redirect_valid;
  assign redir_tgt = word_align(i_redirect_pc);
`endif

  assign o_imem_addr  = pc;
  assign o_inst_valid = (count != '0);
  assign pop          = o_inst_valid && i_inst_ready;
  assign o_halted     = (state == ST_HALT);
  assign o_inst       = o_inst_valid ? fifo_inst[rd_ptr] : 32'h0;
  assign o_inst_pc    = o_inst_valid ? fifo_pc[rd_ptr]   : '0;

  // Next-state, next-PC and FIFO push/flush decisions; redirect beats fetch.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    push      = 1'b0;
    flush     = 1'b0;
    inst_zero = (HALT_ON_ZERO != 0) && (i_imem_inst == 32'h0);
    has_room  = (count < CW'(BUF_DEPTH)) || pop;
    case (state)
      ST_BOOT: begin
        state_nxt = ST_FETCH;
        if (redir) pc_nxt = redir_tgt;
      end
      ST_FETCH: begin
        if (redir) begin
          pc_nxt = redir_tgt;
          flush  = 1'b1;
        end else if (has_room) begin
          if (inst_zero) begin
            state_nxt = ST_HALT;
          end else begin
            push   = 1'b1;
            pc_nxt = pc + ADDR_WIDTH'(4);
          end
        end
      end
      ST_HALT: begin
        if (redir) begin
          pc_nxt    = redir_tgt;
          flush     = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      default: state_nxt = ST_BOOT;
    endcase
  end

  // State and PC registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= ST_BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // FIFO pointers and occupancy; a flush empties the buffer regardless of pop.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= pc;
      fifo_inst[wr_ptr] <= i_imem_inst;
    end
  end

`ifdef IFETCH_MISALIGN_TRAP_EN
  // One-cycle misalign pulse; the offending target is held until the next one.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_misalign    <= 1'b0;
      o_misalign_pc <= '0;
    end else begin
      o_misalign <= redir_mis;
      if (redir_mis) o_misalign_pc <= i_redirect_pc;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl: directed bench for inst_fetch_ctrl in its default build
// (ADDR_WIDTH=32, RESET_PC=0, BUF_DEPTH=2, HALT_ON_ZERO=1).
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ready = 1'b0;
  logic        rv = 1'b0;
  logic [31:0] rpc = 32'h0;
  logic [31:0] addr;
  logic [31:0] inst_in;
  logic        valid;
  logic [31:0] inst;
  logic [31:0] ipc;
  logic        halted;

  logic [31:0] mem [16];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Combinational instruction memory, 16 words mirrored over the address space.
  assign inst_in = mem[addr[5:2]];

  inst_fetch_ctrl dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .o_imem_addr      (addr),
    .i_imem_inst      (inst_in),
    .o_inst_valid     (valid),
    .i_inst_ready     (ready),
    .o_inst           (inst),
    .o_inst_pc        (ipc),
    .i_redirect_valid (rv),
    .i_redirect_pc    (rpc),
    .o_halted         (halted)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    mem[0] = 32'h0010_8113;
    mem[1] = 32'h0010_8193;
    mem[2] = 32'h0031_0233;
    mem[3] = 32'hfe21_8ae3;
    mem[4] = 32'h0000_0000;
    for (int i = 5; i < 16; i++) mem[i] = 32'h0010_0013 + i;

    // Power-on reset and straight-line program ending in the zero word
    rst_n = 1'b0;
    ready = 1'b1;
    tick;
    tick;
    check("rst_valid", valid, 0);
    check("rst_halted", halted, 0);
    check("rst_addr", addr, 32'h0);
    check("rst_head_pc", ipc, 32'h0);
    check("rst_head_inst", inst, 32'h0);
    rst_n = 1'b1;
    tick;
    check("e0_valid", valid, 0);
    tick;
    check("e1_valid", valid, 1);
    check("e1_pc", ipc, 32'h0);
    check("e1_inst", inst, 32'h0010_8113);
    for (int i = 1; i < 4; i++) begin
      tick;
      check("stream_pc", ipc, 32'(i * 4));
      check("stream_inst", inst, mem[i]);
    end
    tick;
    check("halt_flag", halted, 1);
    check("halt_valid", valid, 0);
    check("halt_addr", addr, 32'h10);
    tick;
    check("halt_hold_flag", halted, 1);
    check("halt_hold_addr", addr, 32'h10);

    // Backpressure fills the FIFO and holds the PC
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    ready = 1'b0;
    tick;
    tick;
    check("bp_first_valid", valid, 1);
    for (int i = 0; i < 4; i++) tick;
    check("bp_addr", addr, 32'h8);
    check("bp_head_pc", ipc, 32'h0);
    check("bp_head_inst", inst, 32'h0010_8113);
    ready = 1'b1;
    tick;
    check("drain_pc4", ipc, 32'h4);
    tick;
    check("drain_pc8", ipc, 32'h8);
    tick;
    check("drain_pcC", ipc, 32'hC);
    check("drain_halted", halted, 1);
    check("drain_valid", valid, 1);

    // Redirect while halted with a non-empty FIFO
    ready = 1'b0;
    rv = 1'b1;
    rpc = 32'h0;
    tick;
    rv = 1'b0;
    check("rdh_valid", valid, 0);
    check("rdh_halted", halted, 0);
    check("rdh_addr", addr, 32'h0);
    tick;
    check("rdh_next_valid", valid, 1);
    check("rdh_next_pc", ipc, 32'h0);

    // Redirect coinciding with a pop
    tick;
    check("stall_head_pc", ipc, 32'h0);
    check("stall_addr", addr, 32'h8);
    ready = 1'b1;
    rv = 1'b1;
    rpc = 32'h4;
    tick;
    rv = 1'b0;
    check("rdp_valid", valid, 0);
    check("rdp_addr", addr, 32'h4);
    tick;
    check("rdp_head_pc", ipc, 32'h4);
    check("rdp_head_inst", inst, 32'h0010_8193);

    // Misaligned target is word aligned
    rv = 1'b1;
    rpc = 32'h6;
    tick;
    rv = 1'b0;
    check("mis_addr", addr, 32'h4);
    check("mis_valid", valid, 0);
    tick;
    check("mis_head_pc", ipc, 32'h4);

    // PC wraps past the top of the address space
    rv = 1'b1;
    rpc = 32'hFFFF_FFFC;
    tick;
    rv = 1'b0;
    check("wrap_addr_top", addr, 32'hFFFF_FFFC);
    tick;
    check("wrap_head_pc", ipc, 32'hFFFF_FFFC);
    check("wrap_head_inst", inst, mem[15]);
    check("wrap_addr_zero", addr, 32'h0);

    // Fill the FIFO, then reset mid-stream
    ready = 1'b0;
    tick;
    check("full_head_pc", ipc, 32'hFFFF_FFFC);
    check("full_addr", addr, 32'h4);
    tick;
    check("full_hold_addr", addr, 32'h4);
    check("full_hold_head", ipc, 32'hFFFF_FFFC);
    rst_n = 1'b0;
    tick;
    check("mrst_valid", valid, 0);
    check("mrst_addr", addr, 32'h0);
    check("mrst_halted", halted, 0);
    rst_n = 1'b1;
    ready = 1'b1;
    tick;
    check("mrst_e0_valid", valid, 0);
    tick;
    check("mrst_e1_valid", valid, 1);
    check("mrst_e1_pc", ipc, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
